// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store sequencer, the RAM model and its benches.
package mem_pkg;

  localparam int unsigned MEM_ADDR_WIDTH     = 9;
  localparam int unsigned MEM_DATA_WIDTH     = 32;
  localparam int unsigned MEM_TIMEOUT_CYCLES = 16;
  localparam int unsigned MEM_TO_WIDTH       = 5;

  // RAM access size codes; 2'b10 is reserved and treated as illegal.
  localparam logic [1:0] SZ_WORD    = 2'b11;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACTIVE = 3'd1,
    RESP   = 3'd2,
    ERR    = 3'd3,
    TERR   = 3'd4
  } memState_t;

  // True when the access cannot be issued: bad size code or natural misalignment.
  function automatic logic isMisaligned(input logic [1:0] addrLow, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_WORD: bad = (addrLow != 2'b00);
      SZ_HALF: bad = addrLow[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response handshake plus the RAM strobe bus seen by the sequencer.
// slave: the sequencer's view (serves the CPU, drives the RAM strobe).
// master: the environment's view (CPU issuing requests, RAM answering strobes).
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
) ();

  // CPU side
  logic                  reqValid;
  logic                  reqWrite;
  logic [ADDR_WIDTH-1:0] reqAddr;
  logic [DATA_WIDTH-1:0] reqWData;
  logic [1:0]            reqSize;
  logic                  reqSigned;
  logic                  reqReady;
  logic                  respValid;
  logic [DATA_WIDTH-1:0] respRData;
  logic                  respAlignErr;
  logic                  respTimeoutErr;

  // RAM side
  logic                  memFuncActive;
  logic                  readWrite;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] dataIn;
  logic [1:0]            dataSize;
  logic                  memFuncComplete;
  logic [DATA_WIDTH-1:0] dataOut;

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqWData, reqSize, reqSigned,
    output reqReady, respValid, respRData, respAlignErr, respTimeoutErr,
    output memFuncActive, readWrite, address, dataIn, dataSize,
    input  memFuncComplete, dataOut
  );

  modport master (
    output reqValid, reqWrite, reqAddr, reqWData, reqSize, reqSigned,
    input  reqReady, respValid, respRData, respAlignErr, respTimeoutErr,
    input  memFuncActive, readWrite, address, dataIn, dataSize,
    output memFuncComplete, dataOut
  );

endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// Combinational size/sign extender for RAM read data (RAM returns halves/bytes low-aligned).
module mem_load_extend
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] dataOut,
  input  logic [1:0]            size,
  input  logic                  signExt,
  output logic [DATA_WIDTH-1:0] extData
);

  // Replicate the top bit of the returned unit only when sign extension is requested.
  always_comb begin
    extData = dataOut;
    case (size)
      SZ_HALF: extData = {{(DATA_WIDTH-16){signExt & dataOut[15]}}, dataOut[15:0]};
      SZ_BYTE: extData = {{(DATA_WIDTH-8){signExt & dataOut[7]}}, dataOut[7:0]};
      default: extData = dataOut;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: alignment check, RAM strobe handshake with timeout, load extension.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = MEM_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES,
  parameter int unsigned TO_WIDTH       = MEM_TO_WIDTH
) (
  input logic              Clk,
  input logic              Reset,
  mem_access_ctrl_if.slave bus
);

  localparam logic [TO_WIDTH-1:0] ToLast = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  memState_t             stateQ, stateD;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [DATA_WIDTH-1:0] wDataQ;
  logic [1:0]            sizeQ;
  logic                  writeQ;
  logic                  signedQ;
  logic [TO_WIDTH-1:0]   toCntQ;
  logic [DATA_WIDTH-1:0] rDataQ;
  logic [DATA_WIDTH-1:0] extData;
  logic                  accept;
  logic                  capture;
  logic                  firstEdge;

  assign accept    = (stateQ == IDLE) && bus.reqValid;
  // The RAM still shows complete=1 from the previous access on the first ACTIVE edge.
  assign firstEdge = (toCntQ == '0);

  mem_load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .dataOut(bus.dataOut),
    .size   (sizeQ),
    .signExt(signedQ),
    .extData(extData)
  );

  // State register; async reset aborts any access in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic and capture strobe.
  always_comb begin
    stateD  = stateQ;
    capture = 1'b0;
    case (stateQ)
      IDLE: begin
        if (bus.reqValid) begin
          stateD = isMisaligned(bus.reqAddr[1:0], bus.reqSize) ? ERR : ACTIVE;
        end
      end
      ACTIVE: begin
        if (!firstEdge && bus.memFuncComplete) begin
          stateD  = RESP;
          capture = 1'b1;
        end else if (toCntQ == ToLast) begin
          stateD = TERR;
        end
      end
      RESP, ERR, TERR: stateD = IDLE;
      default:         stateD = IDLE;
    endcase
  end

  // Request latch; held stable for the whole RAM access.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addrQ   <= '0;
      wDataQ  <= '0;
      sizeQ   <= SZ_BYTE;
      writeQ  <= 1'b0;
      signedQ <= 1'b0;
    end else if (accept) begin
      addrQ   <= bus.reqAddr;
      wDataQ  <= bus.reqWData;
      sizeQ   <= bus.reqSize;
      writeQ  <= bus.reqWrite;
      signedQ <= bus.reqSigned;
    end
  end

  // Timeout counter: cleared outside ACTIVE, counts ACTIVE edges.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      toCntQ <= '0;
    end else if (stateQ == ACTIVE) begin
      toCntQ <= toCntQ + TO_WIDTH'(1);
    end else begin
      toCntQ <= '0;
    end
  end

  // Load result register; stores leave it zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rDataQ <= '0;
    end else if (accept) begin
      rDataQ <= '0;
    end else if (capture) begin
      rDataQ <= writeQ ? '0 : extData;
    end
  end

  // Outputs decoded from the registered state so the RAM strobe is glitch-free.
  always_comb begin
    bus.reqReady       = (stateQ == IDLE);
    bus.respValid      = (stateQ == RESP) || (stateQ == ERR) || (stateQ == TERR);
    bus.respRData      = (stateQ == RESP) ? rDataQ : '0;
    bus.respAlignErr   = (stateQ == ERR);
    bus.respTimeoutErr = (stateQ == TERR);
    bus.memFuncActive  = (stateQ == ACTIVE);
    bus.readWrite      = writeQ;
    bus.address        = addrQ;
    bus.dataIn         = wDataQ;
    bus.dataSize       = sizeQ;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: big-endian byte RAM model, vector table, scoreboard queue,
// plus hand sequences for timeout and asynchronous reset mid-access.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  typedef struct {
    logic        write;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] expData;
    logic        expAlign;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        align;
    logic        tout;
  } exp_t;

  localparam int NumVec = 22;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mem_access_ctrl_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus ();

  mem_access_ctrl #(
    .ADDR_WIDTH    (9),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16),
    .TO_WIDTH      (5)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t vecs[NumVec];

  // RAM model: acts once per strobe, one edge after it rises; complete stays high afterwards.
  logic [7:0]  mem [512];
  logic        stall = 1'b0;
  logic        ramBusy = 1'b0;
  logic        ramComplete = 1'b1;
  logic [31:0] ramData = 32'h0;

  assign bus.memFuncComplete = ramComplete;
  assign bus.dataOut         = ramData;

  function automatic logic [31:0] ramRead(input logic [8:0] a, input logic [1:0] sz);
    logic [31:0] r;
    case (sz)
      SZ_WORD: r = {mem[a], mem[a + 9'd1], mem[a + 9'd2], mem[a + 9'd3]};
      SZ_HALF: r = {16'h0, mem[a], mem[a + 9'd1]};
      default: r = {24'h0, mem[a]};
    endcase
    return r;
  endfunction

  always @(posedge Clk) begin
    if (bus.memFuncActive && !stall) begin
      if (!ramBusy) begin
        ramBusy     <= 1'b1;
        ramComplete <= 1'b1;
        if (bus.readWrite) begin
          case (bus.dataSize)
            SZ_WORD: begin
              mem[bus.address]        <= bus.dataIn[31:24];
              mem[bus.address + 9'd1] <= bus.dataIn[23:16];
              mem[bus.address + 9'd2] <= bus.dataIn[15:8];
              mem[bus.address + 9'd3] <= bus.dataIn[7:0];
            end
            SZ_HALF: begin
              mem[bus.address]        <= bus.dataIn[15:8];
              mem[bus.address + 9'd1] <= bus.dataIn[7:0];
            end
            default: mem[bus.address] <= bus.dataIn[7:0];
          endcase
        end else begin
          ramData <= ramRead(bus.address, bus.dataSize);
        end
      end
    end else begin
      if (stall) ramComplete <= 1'b0;
      if (!bus.memFuncActive) ramBusy <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveReq(input vec_t v);
    bus.reqValid  = 1'b1;
    bus.reqWrite  = v.write;
    bus.reqAddr   = v.addr;
    bus.reqWData  = v.wdata;
    bus.reqSize   = v.size;
    bus.reqSigned = v.sgn;
  endtask

  // Called at a negedge with the request driven; returns once the accept edge has passed.
  task automatic waitAccept(input string name, output bit ok);
    int guard = 0;
    while (!bus.reqReady && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    ok = bus.reqReady;
    if (!ok) check({name, " ready"}, 32'(bus.reqReady), 32'd1);
    @(negedge Clk);
    bus.reqValid = 1'b0;
  endtask

  task automatic runVec(input int idx);
    vec_t  v;
    exp_t  e;
    bit    ok;
    bit    strobe;
    int    lat;
    string name;
    v    = vecs[idx];
    name = $sformatf("vec%0d", idx);
    @(negedge Clk);
    driveReq(v);
    waitAccept(name, ok);
    if (!ok) return;
    sb.push_back('{v.expData, v.expAlign, 1'b0});
    lat    = 0;
    strobe = bus.memFuncActive;
    while (!bus.respValid && lat < 40) begin
      @(negedge Clk);
      lat++;
      strobe |= bus.memFuncActive;
    end
    e = sb.pop_front();
    check({name, " respValid"}, 32'(bus.respValid), 32'd1);
    check({name, " latency"}, 32'(lat), v.expAlign ? 32'd0 : 32'd2);
    check({name, " rdata"}, bus.respRData, e.data);
    check({name, " alignErr"}, 32'(bus.respAlignErr), 32'(e.align));
    check({name, " timeoutErr"}, 32'(bus.respTimeoutErr), 32'(e.tout));
    if (v.expAlign) check({name, " no strobe"}, 32'(strobe), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    int   act;
    bit   sawResp;
    vec_t v;
    exp_t e;

    //          write  addr     wdata          size        sgn   expData        align
    vecs[0]  = '{1'b1, 9'h028, 32'h8C070028, SZ_WORD,    1'b0, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 9'h003, 32'h000000F0, SZ_BYTE,    1'b0, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 9'h010, 32'h00008001, SZ_HALF,    1'b0, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 9'h028, 32'h0,        SZ_WORD,    1'b0, 32'h8C070028, 1'b0};
    vecs[4]  = '{1'b0, 9'h003, 32'h0,        SZ_BYTE,    1'b1, 32'hFFFFFFF0, 1'b0};
    vecs[5]  = '{1'b0, 9'h003, 32'h0,        SZ_BYTE,    1'b0, 32'h000000F0, 1'b0};
    vecs[6]  = '{1'b0, 9'h010, 32'h0,        SZ_HALF,    1'b1, 32'hFFFF8001, 1'b0};
    vecs[7]  = '{1'b0, 9'h010, 32'h0,        SZ_HALF,    1'b0, 32'h00008001, 1'b0};
    vecs[8]  = '{1'b1, 9'h040, 32'hDEADBEEF, SZ_WORD,    1'b0, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b0, 9'h040, 32'h0,        SZ_WORD,    1'b0, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{1'b1, 9'h042, 32'hAAAA1234, SZ_HALF,    1'b0, 32'h00000000, 1'b0};
    vecs[11] = '{1'b0, 9'h040, 32'h0,        SZ_WORD,    1'b0, 32'hDEAD1234, 1'b0};
    vecs[12] = '{1'b0, 9'h041, 32'h0,        SZ_BYTE,    1'b1, 32'hFFFFFFAD, 1'b0};
    vecs[13] = '{1'b0, 9'h041, 32'h0,        SZ_WORD,    1'b0, 32'h00000000, 1'b1};
    vecs[14] = '{1'b0, 9'h003, 32'h0,        SZ_HALF,    1'b1, 32'h00000000, 1'b1};
    vecs[15] = '{1'b0, 9'h000, 32'h0,        SZ_ILLEGAL, 1'b0, 32'h00000000, 1'b1};
    vecs[16] = '{1'b1, 9'h1FC, 32'h01020304, SZ_WORD,    1'b0, 32'h00000000, 1'b0};
    vecs[17] = '{1'b0, 9'h1FC, 32'h0,        SZ_WORD,    1'b0, 32'h01020304, 1'b0};
    vecs[18] = '{1'b0, 9'h1FE, 32'h0,        SZ_HALF,    1'b1, 32'h00000304, 1'b0};
    vecs[19] = '{1'b1, 9'h1FF, 32'hFFFFFF85, SZ_BYTE,    1'b1, 32'h00000000, 1'b0};
    vecs[20] = '{1'b0, 9'h1FF, 32'h0,        SZ_BYTE,    1'b1, 32'hFFFFFF85, 1'b0};
    vecs[21] = '{1'b0, 9'h028, 32'h0,        SZ_WORD,    1'b0, 32'h8C070028, 1'b0};

    Reset         = 1'b1;
    bus.reqValid  = 1'b0;
    bus.reqWrite  = 1'b0;
    bus.reqAddr   = '0;
    bus.reqWData  = '0;
    bus.reqSize   = SZ_BYTE;
    bus.reqSigned = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset reqReady", 32'(bus.reqReady), 32'd1);
    check("reset respValid", 32'(bus.respValid), 32'd0);
    check("reset memFuncActive", 32'(bus.memFuncActive), 32'd0);
    check("reset respRData", bus.respRData, 32'd0);
    check("reset ram outputs", {bus.dataIn[29:0] | 30'(bus.address)},
          32'd0);
    check("reset rw/size", {29'd0, bus.readWrite, bus.dataSize}, 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < NumVec; i++) runVec(i);

    // Timeout: RAM never completes; expect 16 strobe cycles then a timeout response.
    @(negedge Clk);
    stall = 1'b1;
    v = '{1'b0, 9'h028, 32'h0, SZ_WORD, 1'b0, 32'h0, 1'b0};
    driveReq(v);
    waitAccept("timeout", ok);
    if (ok) begin
      sb.push_back('{32'h0, 1'b0, 1'b1});
      act = 0;
      while (!bus.respValid && act < 40) begin
        act += int'(bus.memFuncActive);
        @(negedge Clk);
      end
      e = sb.pop_front();
      check("timeout active cycles", 32'(act), 32'd16);
      check("timeout respValid", 32'(bus.respValid), 32'd1);
      check("timeout flag", 32'(bus.respTimeoutErr), 32'(e.tout));
      check("timeout alignErr", 32'(bus.respAlignErr), 32'(e.align));
      check("timeout rdata", bus.respRData, e.data);
      @(negedge Clk);
      check("timeout back to idle", 32'(bus.reqReady), 32'd1);
    end

    // Reset in the middle of a stalled access: strobe drops at once, no response.
    @(negedge Clk);
    driveReq(v);
    waitAccept("rst", ok);
    if (ok) begin
      repeat (3) @(negedge Clk);
      check("rst pre active", 32'(bus.memFuncActive), 32'd1);
      Reset = 1'b1;
      #1;
      check("rst async strobe drop", 32'(bus.memFuncActive), 32'd0);
      check("rst async respValid", 32'(bus.respValid), 32'd0);
      check("rst async reqReady", 32'(bus.reqReady), 32'd1);
      @(negedge Clk);
      Reset   = 1'b0;
      sawResp = 1'b0;
      repeat (20) begin
        @(negedge Clk);
        sawResp |= bus.respValid;
      end
      check("rst no respValid", 32'(sawResp), 32'd0);
    end
    stall = 1'b0;

    // Normal operation resumes after the aborted access.
    runVec(11);
    runVec(13);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
